uart_tx: RTL

- 8N1 UART transmitter. Serialises one byte per frame onto a single line, LSB first.
- Clocked by the same 16x-baud clock as the existing receive path, so one bit period is 16 clk cycles and a frame is 160 cycles.
- Sits between the system logic (command/response source) and the serial TX pin.
- Has a one-deep holding register so the system can queue the next byte while the current frame shifts out.

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_baud_cnt.sv | 39 +++
 rtl/uart_tx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: default bit timing and transmitter state encoding.
// The receive path imports the same defaults so both ends agree on bit timing.
package uart_tx_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Clock cycles from the first start-bit cycle through the last stop-bit cycle.
  function automatic int frame_cycles(input int oversample, input int data_bits);
    return (data_bits + 2) * oversample;
  endfunction

  localparam int FRAME_CYCLES_DEF = frame_cycles(OVERSAMPLE_DEF, DATA_BITS_DEF);

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Oversample counter: wraps at OVERSAMPLE-1 and flags the last cycle of each bit period.
// Held at zero while clr_i is high so a frame always starts on a fresh bit period.
module uart_tx_baud_cnt
  import uart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_tick_o
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-deep holding register; LSB first, line idles high.
// A byte queued during a frame is launched straight after that frame's stop bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] datain,
  output logic                 tx_ready,
  output logic                 tx_int,
  output logic                 data_wr
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 data_wr_q, data_wr_d;
  logic                 tx_int_q, tx_int_d;
  logic                 bit_tick;
  logic                 accept;
  logic                 load;

  uart_tx_baud_cnt #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_q == ST_IDLE),
    .en_i       (state_q != ST_IDLE),
    .bit_tick_o (bit_tick)
  );

  assign accept = tx_start && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load only happens with hold full and accept only with hold empty, so they never collide.
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = datain;
      hold_full_d = 1'b1;
    end

    // Outputs are registered, so they are decoded from the next state.
    case (state_d)
      ST_START: data_wr_d = 1'b0;
      ST_DATA:  data_wr_d = shift_d[bit_d];
      default:  data_wr_d = 1'b1;
    endcase
    tx_int_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      data_wr_q   <= 1'b1;
      tx_int_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      data_wr_q   <= data_wr_d;
      tx_int_q    <= tx_int_d;
    end
  end

  assign tx_ready = !hold_full_q;
  assign tx_int   = tx_int_q;
  assign data_wr  = data_wr_q;

endmodule
